// File: rtl/snes_pad_responder.sv
// snes_pad_responder: device end of the SNES pad serial link (4021-style).
// Define SNES_PAD_TURBO_EN to add turbo auto-fire on the A and B buttons.
module snes_pad_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int TURBO_DIV   = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [11:0] buttons,
`ifdef SNES_PAD_TURBO_EN
  input  logic [1:0]  turbo,
`endif
  input  logic        snes_latch,
  input  logic        snes_clock,
  output logic        snes_data,
  output logic        poll_strobe,
  output logic [4:0]  bit_index
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  localparam int MSB = SYNC_STAGES - 1;

  if (SYNC_STAGES < 2 || TURBO_DIV < 1) begin : g_bad_cfg
    $error("snes_pad_responder: bad parameters");
  end

  logic [MSB:0] lat_sync;
  logic [MSB:0] clk_sync;
  logic         lat_h;
  logic         clk_h;
  logic         lat_s;
  logic         clk_s;
  logic         latch_rise;
  logic         latch_fall;
  logic         clk_rise;

  // Latch idles low, host clock idles high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lat_sync <= '0;
      clk_sync <= '1;
      lat_h    <= 1'b0;
      clk_h    <= 1'b1;
    end else begin
      lat_sync <= {lat_sync[MSB-1:0], snes_latch};
      clk_sync <= {clk_sync[MSB-1:0], snes_clock};
      lat_h    <= lat_sync[MSB];
      clk_h    <= clk_sync[MSB];
    end
  end

  assign lat_s      = lat_sync[MSB];
  assign clk_s      = clk_sync[MSB];
  assign latch_rise = lat_s & ~lat_h;
  assign latch_fall = ~lat_s & lat_h;
  assign clk_rise   = clk_s & ~clk_h;

  state_t      state;
  state_t      state_n;
  logic [15:0] shreg;
  logic [15:0] shreg_n;
  logic [4:0]  idx;
  logic [4:0]  idx_n;
  logic        strobe_q;
  logic        strobe_n;
  logic [11:0] btn_eff;
  logic [15:0] frame;

`ifdef SNES_PAD_TURBO_EN
  localparam int CW = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;

  logic [CW-1:0] poll_cnt;
  logic          toggle;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      poll_cnt <= '0;
      toggle   <= 1'b0;
    end else if (strobe_q) begin
      if (poll_cnt == CW'(TURBO_DIV - 1)) begin
        poll_cnt <= '0;
        toggle   <= ~toggle;
      end else begin
        poll_cnt <= poll_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    btn_eff = buttons;
    if (turbo[0]) btn_eff[8] = buttons[8] & toggle;
    if (turbo[1]) btn_eff[0] = buttons[0] & toggle;
  end
`else
  assign btn_eff = buttons;
`endif

  assign frame = {4'hF, ~btn_eff};

  // A latch edge overrides everything, including a same-cycle clock edge.
  always_comb begin
    state_n  = state;
    shreg_n  = shreg;
    idx_n    = idx;
    strobe_n = 1'b0;
    if (latch_rise) begin
      state_n = LOAD;
      shreg_n = frame;
      idx_n   = 5'd0;
    end else begin
      unique case (state)
        IDLE: ;
        LOAD: begin
          if (latch_fall) begin
            state_n = SHIFT;
          end else if (lat_s) begin
            shreg_n = frame;
            idx_n   = 5'd0;
          end
        end
        SHIFT: begin
          if (clk_rise) begin
            shreg_n = {1'b0, shreg[15:1]};
            idx_n   = idx + 5'd1;
            if (idx == 5'd15) begin
              strobe_n = 1'b1;
              state_n  = DONE;
            end
          end
        end
        DONE: ;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      shreg    <= '1;
      idx      <= 5'd0;
      strobe_q <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      idx      <= idx_n;
      strobe_q <= strobe_n;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      snes_data   <= 1'b1;
      poll_strobe <= 1'b0;
      bit_index   <= 5'd0;
    end else begin
      snes_data   <= shreg[0];
      poll_strobe <= strobe_q;
      bit_index   <= idx;
    end
  end

endmodule

// File: tb/tb_snes_pad_responder.sv
// tb_snes_pad_responder: host-side model driving latch/clock, scoreboarded.
// Exercises the SNES_PAD_TURBO_EN path when that macro is defined.
`timescale 1ns/1ps
module tb_snes_pad_responder;

  localparam int HP = 200;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] buttons = 12'h000;
  logic        snes_latch = 1'b0;
  logic        snes_clock = 1'b1;
  logic        snes_data;
  logic        poll_strobe;
  logic [4:0]  bit_index;
`ifdef SNES_PAD_TURBO_EN
  logic [1:0]  turbo = 2'b00;
`endif

  int checks = 0;
  int failures = 0;
  int exp_idx = 0;
  int polls_total = 0;
  int polls_rst = 0;
  int strobes = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int last_lat = 0;
  bit in_frame = 1'b0;
  logic sb_q[$];

  snes_pad_responder #(
    .SYNC_STAGES(2),
    .TURBO_DIV(2)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .buttons(buttons),
`ifdef SNES_PAD_TURBO_EN
    .turbo(turbo),
`endif
    .snes_latch(snes_latch),
    .snes_clock(snes_clock),
    .snes_data(snes_data),
    .poll_strobe(poll_strobe),
    .bit_index(bit_index)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge snes_clock) rise_cyc = cyc;

  always @(negedge clock) begin
    if (poll_strobe === 1'b1) begin
      strobes  = strobes + 1;
      last_lat = cyc - rise_cyc;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] frame_of(input logic [11:0] b);
    logic [11:0] e;
`ifdef SNES_PAD_TURBO_EN
    logic tog;
    tog = ((polls_rst / 2) % 2) == 1;
`endif
    e = b;
`ifdef SNES_PAD_TURBO_EN
    if (turbo[0]) e[8] = b[8] & tog;
    if (turbo[1]) e[0] = b[0] & tog;
`endif
    return {4'hF, ~e};
  endfunction

  task automatic push_frame();
    logic [15:0] f;
    f = frame_of(buttons);
    sb_q.delete();
    for (int i = 0; i < 16; i++) sb_q.push_back(f[i]);
    exp_idx  = 0;
    in_frame = 1'b1;
  endtask

  task automatic host_latch();
    snes_latch = 1'b1;
    #(2*HP);
    push_frame();
    snes_latch = 1'b0;
    #HP;
  endtask

  task automatic host_bit(input string tag);
    logic e;
    snes_clock = 1'b0;
    #HP;
    e = (sb_q.size() > 0) ? sb_q.pop_front() : 1'b0;
    check(tag, {31'd0, snes_data}, {31'd0, e});
    check({tag, "_idx"}, {27'd0, bit_index}, exp_idx);
    snes_clock = 1'b1;
    if (in_frame && exp_idx < 16) begin
      exp_idx++;
      if (exp_idx == 16) begin
        polls_total++;
        polls_rst++;
      end
    end
    #HP;
  endtask

  task automatic release_reset();
    snes_latch = 1'b0;
    snes_clock = 1'b1;
    @(negedge clock);
    reset_n   = 1'b1;
    polls_rst = 0;
    in_frame  = 1'b0;
    exp_idx   = 0;
    sb_q.delete();
    repeat (10) @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      buttons    = 12'($urandom);
      snes_latch = 1'($urandom);
      snes_clock = 1'($urandom);
      @(negedge clock);
    end
    check("rst_data", {31'd0, snes_data}, 1);
    check("rst_strobe", {31'd0, poll_strobe}, 0);
    check("rst_idx", {27'd0, bit_index}, 0);
    release_reset();
  endtask

  initial begin
    do_reset();
    check("idle_data", {31'd0, snes_data}, 1);
    sb_q.push_back(1'b1);
    sb_q.push_back(1'b1);
    host_bit("idle");
    host_bit("idle");

    buttons = 12'h0A5;
    host_latch();
    for (int i = 0; i < 16; i++) host_bit("frame");
    check("frame_strobes", strobes, polls_total);
    check("strobe_lat", last_lat, 4);

    for (int i = 0; i < 4; i++) host_bit("post");
    check("post_strobes", strobes, polls_total);

    buttons = 12'h0A5;
    host_latch();
    for (int i = 0; i < 7; i++) host_bit("pre_abort");
    buttons = 12'hFFF;
    host_latch();
    check("abort_data", {31'd0, snes_data}, 0);
    check("abort_idx", {27'd0, bit_index}, 0);
    check("abort_strobes", strobes, polls_total);
    for (int i = 0; i < 16; i++) host_bit("reload");
    check("reload_strobes", strobes, polls_total);

    buttons = 12'h001;
    host_latch();
    buttons = 12'h000;
    host_bit("keep");
    host_bit("keep");
    snes_clock = 1'b0;
    #HP;
    snes_latch = 1'b1;
    snes_clock = 1'b1;
    #(2*HP);
    push_frame();
    snes_latch = 1'b0;
    #HP;
    check("sim_data", {31'd0, snes_data}, 1);
    check("sim_idx", {27'd0, bit_index}, 0);
    check("sim_strobes", strobes, polls_total);
    for (int i = 0; i < 16; i++) host_bit("next");

    buttons = 12'hFFF;
    host_latch();
    for (int i = 0; i < 3; i++) host_bit("mid");
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_data", {31'd0, snes_data}, 1);
    check("arst_idx", {27'd0, bit_index}, 0);
    check("arst_strobe", {31'd0, poll_strobe}, 0);
    release_reset();

`ifdef SNES_PAD_TURBO_EN
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    release_reset();
    turbo   = 2'b01;
    buttons = 12'h100;
    for (int p = 0; p < 8; p++) begin
      host_latch();
      for (int i = 0; i < 16; i++) host_bit("turbo");
    end
    check("turbo_strobes", strobes, polls_total);
`endif

    check("total_strobes", strobes, polls_total);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
